// File: rtl/disp_mux_hms.sv
// disp_mux_hms: frame-coherent 6-digit BCD time scanner for a common-anode 7-segment display.
// Optional field blinking is compiled in with `define DMUX_BLINK_EN.
module disp_mux_hms #(
    parameter int SCAN_DIV = 50000
`ifdef DMUX_BLINK_EN
   ,parameter int BLINK_DIV = 12500000
`endif
) (
    input  logic       dmux_clock,
    input  logic       dmux_reset,
    input  logic [1:0] dmux_h_Msd,
    input  logic [3:0] dmux_h_Lsd,
    input  logic [2:0] dmux_m_Msd,
    input  logic [3:0] dmux_m_Lsd,
    input  logic [2:0] dmux_s_Msd,
    input  logic [3:0] dmux_s_Lsd,
`ifdef DMUX_BLINK_EN
    input  logic [1:0] dmux_blink_sel,
`endif
    output logic [5:0] dmux_an,
    output logic [6:0] dmux_seg,
    output logic       dmux_dp
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] PLAST = PW'(SCAN_DIV - 1);

    logic [PW-1:0]   presc_q, presc_d;
    logic [2:0]      idx_q, idx_d;
    logic [5:0][3:0] snap_q, snap_d;
    logic [5:0]      an_q, an_d;
    logic [6:0]      seg_q, seg_d;
    logic            dp_q, dp_d;
    logic            wrap;
    logic [3:0]      digit;
    logic [1:0]      field;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h3F;
        endcase
        return s;
    endfunction

`ifdef DMUX_BLINK_EN
    localparam int BW = $clog2(BLINK_DIV);
    localparam logic [BW-1:0] BLAST = BW'(BLINK_DIV - 1);

    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          phase_q, phase_d;

    always_comb begin
        bcnt_d  = bcnt_q + 1'b1;
        phase_d = phase_q;
        if (bcnt_q == BLAST) begin
            bcnt_d  = '0;
            phase_d = ~phase_q;
        end
    end

    always_ff @(posedge dmux_clock or negedge dmux_reset) begin
        if (!dmux_reset) begin
            bcnt_q  <= '0;
            phase_q <= 1'b0;
        end else begin
            bcnt_q  <= bcnt_d;
            phase_q <= phase_d;
        end
    end
`endif

    always_comb begin
        wrap    = (presc_q == PLAST);
        presc_d = wrap ? '0 : presc_q + 1'b1;
        idx_d   = idx_q;
        snap_d  = snap_q;
        if (wrap) begin
            idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
        end
        // A new frame starts with idx 5->0: latch one coherent time.
        if (wrap && (idx_q == 3'd5)) begin
            snap_d[0] = {2'b00, dmux_h_Msd};
            snap_d[1] = dmux_h_Lsd;
            snap_d[2] = {1'b0, dmux_m_Msd};
            snap_d[3] = dmux_m_Lsd;
            snap_d[4] = {1'b0, dmux_s_Msd};
            snap_d[5] = dmux_s_Lsd;
        end
    end

    always_comb begin
        digit = snap_d[0];
        field = 2'b01;
        case (idx_d)
            3'd0: begin digit = snap_d[0]; field = 2'b01; end
            3'd1: begin digit = snap_d[1]; field = 2'b01; end
            3'd2: begin digit = snap_d[2]; field = 2'b10; end
            3'd3: begin digit = snap_d[3]; field = 2'b10; end
            3'd4: begin digit = snap_d[4]; field = 2'b11; end
            3'd5: begin digit = snap_d[5]; field = 2'b11; end
            default: begin digit = 4'd0; field = 2'b00; end
        endcase
    end

    always_comb begin
        an_d  = 6'h3F;
        seg_d = 7'h7F;
        dp_d  = 1'b1;
        // Slot 0 of each digit stays dark to hide ghosting.
        if (presc_d != '0) begin
            an_d  = ~(6'b1 << idx_d);
            seg_d = bcd_to_seg(digit);
            dp_d  = ~((idx_d == 3'd1) | (idx_d == 3'd3));
`ifdef DMUX_BLINK_EN
            if (phase_d && (dmux_blink_sel != 2'b00) && (dmux_blink_sel == field)) begin
                seg_d = 7'h7F;
            end
`endif
        end
    end

    always_ff @(posedge dmux_clock or negedge dmux_reset) begin
        if (!dmux_reset) begin
            presc_q <= '0;
            idx_q   <= 3'd0;
            snap_q  <= '0;
            an_q    <= 6'h3F;
            seg_q   <= 7'h7F;
            dp_q    <= 1'b1;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
        end
    end

    assign dmux_an  = an_q;
    assign dmux_seg = seg_q;
    assign dmux_dp  = dp_q;

endmodule

// File: tb/tb_disp_mux_hms.sv
// tb_disp_mux_hms: directed vector bench for disp_mux_hms with SCAN_DIV=4, BLINK_DIV=8.
// Cycle k counts negedges since reset release; state at k is presc=k%4, idx=(k/4)%6.
module tb_disp_mux_hms;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] hm;
    logic [3:0] hl;
    logic [2:0] mm;
    logic [3:0] ml;
    logic [2:0] sm;
    logic [3:0] sl;
    logic [1:0] bsel;
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;

    int n_cmp = 0;
    int n_bad = 0;
    int k = 0;

    always #5 clk = ~clk;

`ifdef DMUX_BLINK_EN
    disp_mux_hms #(.SCAN_DIV(4), .BLINK_DIV(8)) dut (
        .dmux_clock(clk), .dmux_reset(rst_n),
        .dmux_h_Msd(hm), .dmux_h_Lsd(hl),
        .dmux_m_Msd(mm), .dmux_m_Lsd(ml),
        .dmux_s_Msd(sm), .dmux_s_Lsd(sl),
        .dmux_blink_sel(bsel),
        .dmux_an(an), .dmux_seg(seg), .dmux_dp(dp)
    );
`else
    disp_mux_hms #(.SCAN_DIV(4)) dut (
        .dmux_clock(clk), .dmux_reset(rst_n),
        .dmux_h_Msd(hm), .dmux_h_Lsd(hl),
        .dmux_m_Msd(mm), .dmux_m_Lsd(ml),
        .dmux_s_Msd(sm), .dmux_s_Lsd(sl),
        .dmux_an(an), .dmux_seg(seg), .dmux_dp(dp)
    );
`endif

    typedef struct {
        logic [1:0]      hm;
        logic [3:0]      hl;
        logic [2:0]      mm;
        logic [3:0]      ml;
        logic [2:0]      sm;
        logic [3:0]      sl;
        logic [5:0][6:0] seg;
    } tv_t;

    localparam logic [5:0][6:0] ZEROS = {6{7'h40}};
    localparam logic [5:0][6:0] S123456 =
        {7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79};
    localparam logic [5:0][6:0] S123457 =
        {7'h78, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79};

    task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s k=%0d: got %h expected %h", nm, k, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        k++;
    endtask

    task automatic apply(input tv_t v);
        hm = v.hm; hl = v.hl; mm = v.mm;
        ml = v.ml; sm = v.sm; sl = v.sl;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        k = 0;
    endtask

    task automatic chk(input string nm, input logic [5:0][6:0] segs);
        int p = k % 4;
        int i = (k / 4) % 6;
        logic [5:0] ean;
        logic [6:0] eseg;
        logic       edp;
        if (p == 0) begin
            ean = 6'h3F; eseg = 7'h7F; edp = 1'b1;
        end else begin
            ean  = ~(6'd1 << i);
            eseg = segs[i];
            edp  = !(i == 1 || i == 3);
`ifdef DMUX_BLINK_EN
            if (((k / 8) % 2) == 1 && bsel != 2'b00 && int'(bsel) == i / 2 + 1)
                eseg = 7'h7F;
`endif
        end
        cmp({nm, " an"}, {2'b00, an}, {2'b00, ean});
        cmp({nm, " seg"}, {1'b0, seg}, {1'b0, eseg});
        cmp({nm, " dp"}, {7'b0, dp}, {7'b0, edp});
    endtask

    task automatic run_two_frames(input string nm, input logic [5:0][6:0] segs);
        for (int c = 0; c < 48; c++) begin
            chk(nm, (k < 24) ? ZEROS : segs);
            tick();
        end
    endtask

    tv_t vec[5];

    initial begin
        vec[0] = '{2'd2, 4'd3, 3'd5, 4'd9, 3'd5, 4'd8,
                   {7'h00, 7'h12, 7'h10, 7'h12, 7'h30, 7'h24}};
        vec[1] = '{2'd1, 4'd2, 3'd3, 4'd4, 3'd5, 4'd6, S123456};
        vec[2] = '{2'd1, 4'hC, 3'd0, 4'd7, 3'd8 & 3'd0, 4'd9,
                   {7'h10, 7'h40, 7'h78, 7'h40, 7'h3F, 7'h79}};
        vec[3] = '{2'd0, 4'd0, 3'd0, 4'd0, 3'd0, 4'd0, ZEROS};
        vec[4] = '{2'd3, 4'hF, 3'd7, 4'hA, 3'd6, 4'hE,
                   {7'h3F, 7'h02, 7'h3F, 7'h78, 7'h3F, 7'h30}};

        bsel  = 2'b00;
        rst_n = 1'b0;
        apply(vec[1]);

        repeat (3) @(negedge clk);
        cmp("rst an", {2'b00, an}, 8'h3F);
        cmp("rst seg", {1'b0, seg}, 8'h7F);
        cmp("rst dp", {7'b0, dp}, 8'h01);
        rst_n = 1'b1;
        k = 0;
        for (int c = 0; c < 14; c++) begin
            chk("rel", ZEROS);
            tick();
        end
        cmp("idx3 an", {2'b00, an}, 8'h37);
        rst_n = 1'b0;
        #1;
        cmp("rerst an", {2'b00, an}, 8'h3F);
        cmp("rerst seg", {1'b0, seg}, 8'h7F);
        cmp("rerst dp", {7'b0, dp}, 8'h01);
        @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            apply(vec[v]);
            do_reset();
            run_two_frames($sformatf("vec%0d", v), vec[v].seg);
        end

        apply(vec[1]);
        do_reset();
        for (int c = 0; c < 72; c++) begin
            chk("coh", (k < 24) ? ZEROS : (k < 48) ? S123456 : S123457);
            if (k == 37) sl = 4'd7;
            tick();
        end

`ifdef DMUX_BLINK_EN
        apply(vec[1]);
        bsel = 2'b01;
        do_reset();
        run_two_frames("blink01", S123456);
        bsel = 2'b00;
        do_reset();
        run_two_frames("blink00", S123456);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
